// File: rtl/reg_bank_pkg.sv
// Shared defaults and address qualification for the multi-port register bank.
package reg_bank_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefDepth = 8;

    // An address is usable if it maps to a real register and is not the hardwired zero register.
    function automatic logic addr_ok(input int unsigned addr,
                                     input int unsigned depth,
                                     input int unsigned zero_r0);
        return (addr < depth) && !((zero_r0 != 0) && (addr == 0));
    endfunction

endpackage

// File: rtl/reg_bank_rd_port.sv
// One registered read port: write-bypass mux, scoreboard lookup and output registers.
module reg_bank_rd_port
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned DEPTH   = DefDepth,
    parameter int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AW-1:0]               rd_addr,
    input  logic                        rd_en,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem,
    input  logic [DEPTH-1:0]            pend_nxt,
    input  logic                        wr_ok,
    input  logic [AW-1:0]               wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_busy
);

    logic             rd_ok;
    logic             wr_hit;
    logic [WIDTH-1:0] data_d;
    logic             busy_d;

    assign rd_ok  = addr_ok(32'(rd_addr), DEPTH, ZERO_R0);
    // wr_ok already excludes invalid and zero-register writes, so a hit is always a real write.
    assign wr_hit = wr_ok && (wr_addr == rd_addr);

    // Select next read value: bypassed write data, stored contents, or zero for unusable addresses.
    always_comb begin
        data_d = '0;
        busy_d = 1'b0;
        if (rd_ok) begin
            data_d = wr_hit ? wr_data : mem[rd_addr];
            busy_d = pend_nxt[rd_addr];
        end
    end

    // Output registers update only on an enabled read, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (rd_en) begin
            rd_data <= data_d;
            rd_busy <= busy_d;
        end
    end

endmodule

// File: rtl/reg_bank_mp.sv
// Register file with two registered read ports, one write port and a pending scoreboard.
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned DEPTH   = DefDepth,
    parameter int unsigned AW      = $clog2(DEPTH),
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra_addr,
    input  logic              ra_en,
    input  logic [AW-1:0]     rb_addr,
    input  logic              rb_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              rsv_en,
    output logic [WIDTH-1:0]  ra_data,
    output logic [WIDTH-1:0]  rb_data,
    output logic              ra_busy,
    output logic              rb_busy,
    output logic [DEPTH-1:0]  pend_vec
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]            pend_q, pend_d;
    logic                        wr_ok;
    logic                        rsv_ok;

    assign wr_ok  = wr_en && addr_ok(32'(wr_addr), DEPTH, ZERO_R0);
    assign rsv_ok = rsv_en && addr_ok(32'(rsv_addr), DEPTH, ZERO_R0);

    // Next storage and scoreboard state; reserve is applied after write so a new producer wins.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_ok) begin
            mem_d[wr_addr]  = wr_data;
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[rsv_addr] = 1'b1;
        end
    end

    // Storage array and scoreboard registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q  <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    assign pend_vec = pend_q;

    reg_bank_rd_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_port_a (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (ra_addr),
        .rd_en    (ra_en),
        .mem      (mem_q),
        .pend_nxt (pend_d),
        .wr_ok    (wr_ok),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (ra_data),
        .rd_busy  (ra_busy)
    );

    reg_bank_rd_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_port_b (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rb_addr),
        .rd_en    (rb_en),
        .mem      (mem_q),
        .pend_nxt (pend_d),
        .wr_ok    (wr_ok),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rb_data),
        .rd_busy  (rb_busy)
    );

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench for reg_bank_mp: default, zero-register and non-power-of-two depth instances.
module tb_reg_bank_mp;

    logic        clk;
    logic        rst;
    logic [2:0]  ra_addr, rb_addr, wr_addr, rsv_addr;
    logic        ra_en, rb_en, wr_en, rsv_en;
    logic [15:0] wr_data;

    logic [15:0] a_ra, a_rb, z_ra, z_rb, d_ra, d_rb;
    logic        a_rab, a_rbb, z_rab, z_rbb, d_rab, d_rbb;
    logic [7:0]  a_pend, z_pend;
    logic [5:0]  d_pend;

    int passed = 0;
    int total  = 0;
    int nfail  = 0;

    reg_bank_mp dut (
        .clk(clk), .rst(rst), .ra_addr(ra_addr), .ra_en(ra_en), .rb_addr(rb_addr), .rb_en(rb_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .rsv_addr(rsv_addr), .rsv_en(rsv_en),
        .ra_data(a_ra), .rb_data(a_rb), .ra_busy(a_rab), .rb_busy(a_rbb), .pend_vec(a_pend)
    );

    reg_bank_mp #(.ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .ra_addr(ra_addr), .ra_en(ra_en), .rb_addr(rb_addr), .rb_en(rb_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .rsv_addr(rsv_addr), .rsv_en(rsv_en),
        .ra_data(z_ra), .rb_data(z_rb), .ra_busy(z_rab), .rb_busy(z_rbb), .pend_vec(z_pend)
    );

    reg_bank_mp #(.DEPTH(6)) dut_d6 (
        .clk(clk), .rst(rst), .ra_addr(ra_addr), .ra_en(ra_en), .rb_addr(rb_addr), .rb_en(rb_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .rsv_addr(rsv_addr), .rsv_en(rsv_en),
        .ra_data(d_ra), .rb_data(d_rb), .ra_busy(d_rab), .rb_busy(d_rbb), .pend_vec(d_pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {ra_addr, rb_addr, wr_addr, rsv_addr} = '0;
        {ra_en, rb_en, wr_en, rsv_en} = '0;
        wr_data = '0;

        // Reset state
        #1;
        check("rst_ra", a_ra, 16'h0);
        check("rst_pend", a_pend, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Read every register on both ports after reset
        for (int i = 0; i < 8; i++) begin
            ra_addr = 3'(i);
            rb_addr = 3'(i);
            ra_en   = 1'b1;
            rb_en   = 1'b1;
            tick();
            check("init_ra", {a_ra, 7'd0, a_rab}, 24'h0);
            check("init_rb", {a_rb, 7'd0, a_rbb}, 24'h0);
        end
        check("init_pend", a_pend, 8'h00);
        ra_en = 1'b0;
        rb_en = 1'b0;

        // Write R1 then read it next cycle
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0404;
        tick();
        wr_en = 1'b0; ra_addr = 3'd1; ra_en = 1'b1;
        tick();
        check("rd_r1", a_ra, 16'h0404);

        // Disabled port holds its value
        ra_en = 1'b0; ra_addr = 3'd2;
        tick();
        check("hold_ra", a_ra, 16'h0404);

        // Write R2 with same-cycle read on B: bypass
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0407; rb_addr = 3'd2; rb_en = 1'b1;
        tick();
        wr_en = 1'b0; rb_en = 1'b0;
        check("bypass_r2", a_rb, 16'h0407);

        // Reserve R3
        rsv_en = 1'b1; rsv_addr = 3'd3;
        tick();
        rsv_en = 1'b0;
        check("rsv_pend", a_pend, 8'h08);
        ra_addr = 3'd3; ra_en = 1'b1;
        tick();
        check("rsv_busy", {a_ra, 7'd0, a_rab}, {16'h0000, 8'h01});

        // Write R3 without reserve clears pending; bypass also shows busy cleared
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        tick();
        wr_en = 1'b0;
        check("wr3_pend", a_pend, 8'h00);
        check("wr3_read", {a_ra, 7'd0, a_rab}, {16'h1234, 8'h00});

        // Write and reserve R3 together: reserve wins
        wr_en = 1'b1; rsv_en = 1'b1; rsv_addr = 3'd3; rb_addr = 3'd3; rb_en = 1'b1; ra_en = 1'b0;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        check("rw3_pend", a_pend, 8'h08);
        check("rw3_read", {a_rb, 7'd0, a_rbb}, {16'h1234, 8'h01});
        check("rw3_hold_a", a_ra, 16'h1234);

        // Both ports on the same address
        ra_addr = 3'd1; rb_addr = 3'd1; ra_en = 1'b1; rb_en = 1'b1;
        tick();
        check("dual_same", {a_ra, a_rb}, {16'h0404, 16'h0404});

        // Write and reserve R0 with bypass read on A
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 3'd0;
        ra_addr = 3'd0; rb_en = 1'b0;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        check("r0_plain", {a_ra, 7'd0, a_rab}, {16'hFFFF, 8'h01});
        check("r0_plain_pend", a_pend, 8'h09);
        check("r0_zero", {z_ra, 7'd0, z_rab}, {16'h0000, 8'h00});
        check("r0_zero_pend", z_pend, 8'h08);
        ra_en = 1'b0; rb_addr = 3'd0; rb_en = 1'b1;
        tick();
        check("r0_zero_b", {z_rb, 7'd0, z_rbb}, {16'h0000, 8'h00});
        check("r0_plain_b", {a_rb, 7'd0, a_rbb}, {16'hFFFF, 8'h01});

        // Out-of-range write/reserve on the depth-6 bank
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hBEEF; rsv_en = 1'b1; rsv_addr = 3'd6;
        ra_addr = 3'd7; ra_en = 1'b1; rb_addr = 3'd6; rb_en = 1'b1;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        check("d6_ra7", {d_ra, 7'd0, d_rab}, {16'h0000, 8'h00});
        check("d6_rb6", {d_rb, 7'd0, d_rbb}, {16'h0000, 8'h00});
        check("d6_pend", d_pend, 6'h09);
        check("d8_ra7", {a_ra, 7'd0, a_rab}, {16'hBEEF, 8'h00});
        check("d8_rb6", {a_rb, 7'd0, a_rbb}, {16'h0000, 8'h01});
        check("d8_pend", a_pend, 8'h49);
        rb_addr = 3'd3;
        tick();
        check("d6_ra7_again", d_ra, 16'h0000);
        check("d6_r3", {d_rb, 7'd0, d_rbb}, {16'h1234, 8'h01});

        // Asynchronous reset mid-operation
        ra_addr = 3'd1; rb_addr = 3'd3;
        tick();
        check("pre_rst", {a_ra, 7'd0, a_rbb}, {16'h0404, 8'h01});
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h5555; rsv_en = 1'b1; rsv_addr = 3'd5;
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_ra", a_ra, 16'h0);
        check("rst_async_rb", {a_rb, 7'd0, a_rbb}, 24'h0);
        check("rst_async_pend", a_pend, 8'h00);
        tick();
        rst = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
        tick();
        check("post_rst_r1", a_ra, 16'h0);
        check("post_rst_r3", {a_rb, 7'd0, a_rbb}, 24'h0);
        check("post_rst_pend", a_pend, 8'h00);
        check("post_rst_d6", d_pend, 6'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
